door_sequencer: RTL

DOOR_SEQUENCER -- requirements
Module: door_sequencer

---
 rtl/door_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/door_sequencer.sv
// door_sequencer: opens a door in STAGES steps, dwells HOLD_TICKS cycles at
// full open, then closes in STAGES steps. close shortens the dwell, pause
// extends it (bounded to MAX_PAUSE cycles per door cycle), obstruct reopens a
// closing door, and dropping st_open aborts straight back to IDLE.
//
// Ports
//   CP         in   clock, rising edge
//   CR         in   asynchronous active-low clear
//   st_open    in   door-cycle enable; rising edge starts a cycle
//   close      in   shorten dwell to CLOSE_LEFT remaining cycles
//   pause      in   freeze dwell counter
//   obstruct   in   reopen while closing
//   disp_stage out  door position, 0 closed .. STAGES open
//   count      out  dwell counter
//   state      out  IDLE=0, OPENING=1, HOLD=2, CLOSING=3
//   end_open   out  one-cycle pulse on normal completion
//   busy       out  state != IDLE
//
// state   | meaning
// IDLE    | door closed, waiting for a st_open rising edge
// OPENING | disp_stage stepping up toward STAGES
// HOLD    | fully open, count running toward HOLD_TICKS-1
// CLOSING | disp_stage stepping down toward 0
module door_sequencer #(
  parameter int CNT_W      = 7,
  parameter int STAGE_W    = 2,
  parameter int STAGES     = 3,
  parameter int HOLD_TICKS = 21,
  parameter int CLOSE_LEFT = 3,
  parameter int MAX_PAUSE  = 10
) (
  input  logic               CP,
  input  logic               CR,
  input  logic               st_open,
  input  logic               close,
  input  logic               pause,
  input  logic               obstruct,
  output logic [STAGE_W-1:0] disp_stage,
  output logic [CNT_W-1:0]   count,
  output logic [1:0]         state,
  output logic               end_open,
  output logic               busy
);

  localparam int PAUSE_W = (MAX_PAUSE < 1) ? 1 : $clog2(MAX_PAUSE + 1);

  localparam logic [STAGE_W-1:0] STAGE_FULL = STAGE_W'(STAGES);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0]   CNT_CLOSE  = CNT_W'(HOLD_TICKS - CLOSE_LEFT);
  localparam logic [PAUSE_W-1:0] PAUSE_MAX  = PAUSE_W'(MAX_PAUSE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    HOLD    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PAUSE_W-1:0]   pause_cnt_q, pause_cnt_d;
  logic                 end_open_q, end_open_d;
  logic                 st_d_q, st_d_d;
  logic                 start;

  assign start = st_open & ~st_d_q;

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      count_q     <= '0;
      pause_cnt_q <= '0;
      end_open_q  <= 1'b0;
      st_d_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      count_q     <= count_d;
      pause_cnt_q <= pause_cnt_d;
      end_open_q  <= end_open_d;
      st_d_q      <= st_d_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    count_d     = count_q;
    pause_cnt_d = pause_cnt_q;
    end_open_d  = 1'b0;
    st_d_d      = st_open;

    if (state_q == IDLE) begin
      stage_d     = '0;
      count_d     = '0;
      pause_cnt_d = '0;
      if (start) state_d = OPENING;
    end else if (!st_open) begin
      // Abort outranks every other input.
      state_d     = IDLE;
      stage_d     = '0;
      count_d     = '0;
      pause_cnt_d = '0;
    end else begin
      unique case (state_q)
        OPENING: begin
          // The >= also covers a reopen from STAGES (obstruct on the first
          // closing cycle), so the stage never passes STAGES.
          if (stage_q >= STAGE_LAST) begin
            stage_d = STAGE_FULL;
            state_d = HOLD;
            count_d = '0;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end
        HOLD: begin
          if (count_q == CNT_LAST) begin
            state_d = CLOSING;
            count_d = '0;
          end else if (close && (count_q < CNT_CLOSE)) begin
            count_d = CNT_CLOSE;
          end else if (pause && (pause_cnt_q < PAUSE_MAX)) begin
            pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        CLOSING: begin
          if (obstruct) begin
            state_d = OPENING;
          end else begin
            stage_d = stage_q - STAGE_W'(1);
            if (stage_q == STAGE_W'(1)) begin
              state_d    = IDLE;
              end_open_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign disp_stage = stage_q;
  assign count      = count_q;
  assign state      = state_q;
  assign end_open   = end_open_q;
  assign busy       = (state_q != IDLE);

endmodule
